// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, ID branch squash, multi-cycle memory freeze.
// Optional stall performance counter is built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
    parameter int REG_W       = 5,
    parameter int ZERO_REG    = 31,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_branch_taken,
    input  logic             mem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam int WC_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [WC_W-1:0] WC_INIT = WC_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_nxt;
    logic            lu;
    logic            freeze;

    always_comb begin
        lu = ex_mem_read && ex_reg_write && (ex_rd != REG_W'(ZERO_REG)) &&
             ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        freeze      = 1'b0;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        case (state)
            RUN: begin
                if (mem_req && (MEM_LATENCY > 0)) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WC_INIT;
                end
            end
            MEM_WAIT: begin
                // Release cycle ignores mem_req: it still belongs to the access just serviced.
                if (wait_cnt != '0) begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt - WC_W'(1);
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (reset || freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (lu) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX; a same-cycle branch waits.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (!pc_en && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    assign stall_cycles = cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed + randomized bench for hazard_stall_unit against a cycle-level behavioural model.
module tb_hazard_stall_unit;

    localparam int REG_W = 5;
    localparam int ZERO_REG = 31;
    localparam int L = 2;
    localparam int CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [REG_W-1:0] id_rn, id_rm, ex_rd;
    logic id_uses_rn, id_uses_rm, ex_mem_read, ex_reg_write, id_branch_taken, mem_req;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic [CNT_W-1:0] stall_cycles;

    int checks = 0;
    int passed = 0;

    // Model: age = -1 when no access is in flight, else index of the current cycle since it began.
    int age = -1;
    int cnt = 0;

    hazard_stall_unit #(.REG_W(REG_W), .ZERO_REG(ZERO_REG), .MEM_LATENCY(L), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .id_branch_taken(id_branch_taken), .mem_req(mem_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
    task automatic cyc(input bit rst, input int rn, input int rm, input bit urn, input bit urm,
                       input bit mrd, input bit rwr, input int rd, input bit br, input bit mreq);
        bit lu, starting, frozen;
        bit e_pc, e_ifid, e_other, f_ifid, f_idex;
        reset = rst; id_rn = REG_W'(rn); id_rm = REG_W'(rm); id_uses_rn = urn; id_uses_rm = urm;
        ex_mem_read = mrd; ex_reg_write = rwr; ex_rd = REG_W'(rd); id_branch_taken = br; mem_req = mreq;
        @(negedge clk);
        lu = mrd && rwr && (rd != ZERO_REG) && ((urn && rn == rd) || (urm && rm == rd));
        starting = (age < 0) && mreq && (L > 0);
        frozen = starting || (age >= 1 && age < L);
        if (rst || frozen) begin
            e_pc = 0; e_ifid = 0; e_other = 0; f_ifid = 0; f_idex = 0;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_other = 1; f_ifid = 0; f_idex = 1;
        end else begin
            e_pc = 1; e_ifid = 1; e_other = 1; f_ifid = br; f_idex = 0;
        end
        chk("pc_en", pc_en, e_pc);
        chk("if_id_en", if_id_en, e_ifid);
        chk("id_ex_en", id_ex_en, e_other);
        chk("ex_mem_en", ex_mem_en, e_other);
        chk("mem_wb_en", mem_wb_en, e_other);
        chk("if_id_flush", if_id_flush, f_ifid);
        chk("id_ex_flush", id_ex_flush, f_idex);
        chk("stall_cycles", stall_cycles, cnt);
        @(posedge clk);
        if (rst) begin
            age = -1; cnt = 0;
        end else begin
            if (PERF && !e_pc && cnt < (2**CNT_W - 1)) cnt++;
            if (starting) age = (L == 1) ? 1 : 1;
            else if (age >= 1) age = (age == L) ? -1 : age + 1;
        end
        #1;
    endtask

    task automatic idle(input bit rst);
        cyc(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle(1); idle(1);
        idle(0);
        // Load-use on rn, then the following cycle runs freely.
        cyc(0, 3, 7, 1, 0, 1, 1, 3, 0, 0);
        idle(0);
        // Load-use via rm; uses flag clear on matching rn must not trigger.
        cyc(0, 9, 4, 0, 1, 1, 1, 4, 0, 0);
        cyc(0, 4, 9, 0, 1, 1, 1, 4, 0, 0);
        // Zero register never hazards.
        cyc(0, 31, 31, 1, 1, 1, 1, 31, 0, 0);
        // Memory wait with mem_req held through the release cycle.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        // Branch alone, then branch with load-use, then branch on the release cycle.
        cyc(0, 1, 2, 1, 1, 1, 1, 6, 1, 0);
        cyc(0, 6, 2, 1, 1, 1, 1, 6, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Reset mid-wait abandons the access.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0); idle(0);
        // Long mem_req run drives the 4-bit counter to saturation when built.
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        // Randomized traffic with registers drawn from a small pool to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            int pool[4];
            pool[0] = 3; pool[1] = 5; pool[2] = 31; pool[3] = $urandom_range(0, 31);
            cyc(($urandom_range(0, 59) == 0),
                pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                pool[$urandom_range(0, 3)], ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
